// File: rtl/watch_pkg.sv
// watch_pkg: shared state encoding and field helpers for the watch edit controller.
package watch_pkg;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_SEC  = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_HOUR = 2'd3;

    // State codes equal the field codes so the field output is the state itself.
    typedef enum logic [1:0] {
        IDLE     = FIELD_NONE,
        SEL_SEC  = FIELD_SEC,
        SEL_MIN  = FIELD_MIN,
        SEL_HOUR = FIELD_HOUR
    } state_e;

    function automatic state_e next_sel(input state_e s);
        return s == SEL_SEC ? SEL_MIN : s == SEL_MIN ? SEL_HOUR : SEL_SEC;
    endfunction

    function automatic logic [2:0] field_onehot(input state_e s);
        return s == SEL_SEC ? 3'b001 : s == SEL_MIN ? 3'b010 : s == SEL_HOUR ? 3'b100 : 3'b000;
    endfunction

endpackage

// File: rtl/ms_strobe.sv
// ms_strobe: free-running cycle divider with sync clear; one-cycle strobe every DIV cycles.
module ms_strobe #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic stb_o
);

    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign stb_o = cnt_q == W'(DIV - 1);

    always_ff @(posedge clk) begin
        if (reset || clr_i) cnt_q <= '0;
        else cnt_q <= stb_o ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: edit-mode field selection, press/auto-repeat adjust ticks,
// idle timeout and blink strobe for the watch datapath.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int MS_DIV     = 100_000,
    parameter int HOLD_MS    = 500,
    parameter int REPEAT_MS  = 100,
    parameter int TIMEOUT_MS = 10_000,
    parameter int BLINK_MS   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       tick_sec_up,
    output logic       tick_min_up,
    output logic       tick_hour_up,
    output logic       tick_sec_down,
    output logic       tick_min_down,
    output logic       tick_hour_down,
    output logic [1:0] field,
    output logic       edit_active,
    output logic       blink
);

    localparam int HMAX = HOLD_MS > REPEAT_MS ? HOLD_MS : REPEAT_MS;
    localparam int HW   = HMAX > 1 ? $clog2(HMAX) : 1;
    localparam int TW   = TIMEOUT_MS > 1 ? $clog2(TIMEOUT_MS) : 1;
    localparam int BW   = BLINK_MS > 1 ? $clog2(BLINK_MS) : 1;

    state_e        state_q, state_d;
    logic          sw_q, nx_q, up_q, dn_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] to_q, to_d;
    logic [BW-1:0] bl_q, bl_d;
    logic          arm_q, arm_d, rep_q, rep_d, dir_q, dir_d, blink_q, blink_d;
    logic [2:0]    tku_q, tku_d, tkd_q, tkd_d;
    logic          stb, clr_div, timeout, lone_up, lone_dn, any_rise, held_ok, blink_wrap;
    logic [2:0]    oh;

    ms_strobe #(.DIV(MS_DIV)) u_ms (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_div),
        .stb_o (stb)
    );

    assign lone_up    = btn_up & ~up_q & ~btn_down;
    assign lone_dn    = btn_down & ~dn_q & ~btn_up;
    assign any_rise   = (btn_next & ~nx_q) | (btn_up & ~up_q) | (btn_down & ~dn_q);
    assign timeout    = stb && to_q == TW'(TIMEOUT_MS - 1);
    assign blink_wrap = stb && bl_q == BW'(BLINK_MS - 1);
    assign held_ok    = dir_q ? (btn_down & ~btn_up) : (btn_up & ~btn_down);
    assign oh         = field_onehot(state_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            {sw_q, nx_q, up_q, dn_q} <= '0;
            hold_q  <= '0;
            to_q    <= '0;
            bl_q    <= '0;
            {arm_q, rep_q, dir_q, blink_q} <= '0;
            tku_q   <= '0;
            tkd_q   <= '0;
        end else begin
            state_q <= state_d;
            {sw_q, nx_q, up_q, dn_q} <= {sw_mode, btn_next, btn_up, btn_down};
            hold_q  <= hold_d;
            to_q    <= to_d;
            bl_q    <= bl_d;
            {arm_q, rep_q, dir_q, blink_q} <= {arm_d, rep_d, dir_d, blink_d};
            tku_q   <= tku_d;
            tkd_q   <= tkd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        to_d    = '0;
        bl_d    = '0;
        arm_d   = 1'b0;
        rep_d   = rep_q;
        dir_d   = dir_q;
        blink_d = 1'b0;
        tku_d   = '0;
        tkd_d   = '0;
        clr_div = 1'b0;
        if (state_q == IDLE) begin
            state_d = sw_mode && !sw_q ? SEL_SEC : IDLE;
            blink_d = sw_mode && !sw_q;
        end else if (!sw_mode || timeout) begin
            state_d = IDLE;
        end else begin
            to_d    = any_rise ? '0 : to_q + TW'(stb);
            bl_d    = blink_wrap ? '0 : bl_q + BW'(stb);
            blink_d = blink_q ^ blink_wrap;
            hold_d  = hold_q + HW'(stb & arm_q);
            if (btn_next && !nx_q) begin
                state_d = next_sel(state_q);
                blink_d = 1'b1;
                bl_d    = '0;
            end else if (lone_up || lone_dn) begin
                tku_d   = lone_dn ? 3'b000 : oh;
                tkd_d   = lone_dn ? oh : 3'b000;
                arm_d   = 1'b1;
                dir_d   = lone_dn;
                rep_d   = 1'b0;
                hold_d  = '0;
                clr_div = 1'b1;
            end else if (arm_q && held_ok) begin
                arm_d = 1'b1;
                // First repeat after HOLD_MS, then every REPEAT_MS, counted on the restarted ms grid.
                if (stb && hold_q == HW'((rep_q ? REPEAT_MS : HOLD_MS) - 1)) begin
                    tku_d  = dir_q ? 3'b000 : oh;
                    tkd_d  = dir_q ? oh : 3'b000;
                    rep_d  = 1'b1;
                    hold_d = '0;
                end
            end
        end
    end

    assign {tick_hour_up, tick_min_up, tick_sec_up}       = tku_q;
    assign {tick_hour_down, tick_min_down, tick_sec_down} = tkd_q;
    assign field       = state_q;
    assign edit_active = state_q != IDLE;
    assign blink       = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: table vectors, hand sequences for repeat/conflict/exit/timeout,
// and randomized stimulus against a time-based reference model.
module tb_watch_set_ctrl;

    logic       clk = 1'b0;
    logic       reset, sw_mode, btn_next, btn_up, btn_down;
    logic       tsu, tmu, thu, tsd, tmd, thd;
    logic [1:0] field;
    logic       edit_active, blink;
    logic [5:0] tk;
    int         checks = 0;
    int         errors = 0;

    // Tick bit order: {hour_dn, min_dn, sec_dn, hour_up, min_up, sec_up}.
    assign tk = {thd, tmd, tsd, thu, tmu, tsu};

    always #5 clk = ~clk;

    watch_set_ctrl #(
        .MS_DIV(10), .HOLD_MS(5), .REPEAT_MS(2), .TIMEOUT_MS(50), .BLINK_MS(3)
    ) dut (
        .clk(clk), .reset(reset), .sw_mode(sw_mode), .btn_next(btn_next),
        .btn_up(btn_up), .btn_down(btn_down),
        .tick_sec_up(tsu), .tick_min_up(tmu), .tick_hour_up(thu),
        .tick_sec_down(tsd), .tick_min_down(tmd), .tick_hour_down(thd),
        .field(field), .edit_active(edit_active), .blink(blink)
    );

    typedef struct {
        logic       sw, nx, up, dn;
        logic [1:0] f;
        logic [5:0] t;
        logic       bl;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sw, input logic nx, input logic up, input logic dn);
        sw_mode = sw; btn_next = nx; btn_up = up; btn_down = dn;
    endtask

    initial begin
        int mf, press, c;
        logic armed, mdir, ps, pn, pu, pd;
        logic [5:0] et;
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 6'h00, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 6'h01, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 6'h00, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 6'h00, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 6'h00, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 6'h00, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 6'h00, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 6'h00, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 6'h00, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 6'h00, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 6'h00, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 6'h00, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 6'h00, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 6'h10, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 6'h00, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 6'h00, 1'b1};

        reset = 1'b1;
        drive(0, 0, 0, 0);
        cyc();
        cyc();
        chk("reset_ticks", tk, 0);
        chk("reset_field", field, 0);
        chk("reset_edit", edit_active, 0);
        chk("reset_blink", blink, 0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].sw, tbl[i].nx, tbl[i].up, tbl[i].dn);
            cyc();
            chk("vec_ticks", tk, tbl[i].t);
            chk("vec_field", field, tbl[i].f);
            chk("vec_edit", edit_active, tbl[i].f != 0);
            chk("vec_blink", blink, tbl[i].bl);
        end

        // Hold down in SEL_MIN: ticks one cycle after press, then +50, +70, +90, +110.
        drive(1, 0, 0, 1);
        for (int j = 0; j < 120; j++) begin
            cyc();
            chk("repeat_ticks", tk, (j == 0 || j == 50 || j == 70 || j == 90 || j == 110) ? 6'h10 : 6'h00);
        end
        drive(1, 0, 0, 0);
        cyc();
        cyc();

        // Conflict: up held, down joins then leaves; only the initial press ticks.
        for (int j = 0; j < 150; j++) begin
            drive(1, 0, 1, j >= 10 && j < 70);
            cyc();
            chk("conflict_ticks", tk, j == 0 ? 6'h02 : 6'h00);
        end
        drive(1, 0, 0, 0);
        cyc();
        cyc();

        // Drop sw_mode mid-repeat while up stays held.
        for (int j = 0; j < 100; j++) begin
            drive(j < 60, 0, 1, 0);
            cyc();
            chk("exit_ticks", tk, (j == 0 || j == 50) ? 6'h02 : 6'h00);
            if (j == 59 || j == 60) chk("exit_field", field, j < 60 ? 2 : 0);
        end
        drive(0, 0, 0, 0);
        cyc();

        // Re-entry and idle timeout (50 ms = 491..500 cycles after entry).
        drive(1, 0, 0, 0);
        cyc();
        chk("entry_field", field, 1);
        chk("entry_blink", blink, 1);
        for (int j = 1; j <= 540; j++) begin
            cyc();
            if (j == 40) chk("blink_toggled", blink, 0);
            if (j == 485) chk("pre_timeout_field", field, 1);
            if (j == 510) begin
                chk("timeout_field", field, 0);
                chk("timeout_edit", edit_active, 0);
                chk("timeout_blink", blink, 0);
            end
            if (j == 540) chk("no_reentry_field", field, 0);
        end
        drive(0, 0, 0, 0);
        cyc();
        cyc();

        // Randomized: model predicts ticks from elapsed time since the press.
        mf = 0; armed = 0; mdir = 0; press = 0; c = 0;
        {ps, pn, pu, pd} = '0;
        for (int s = 0; s < 80; s++) begin
            int dur;
            logic sw, nx, up, dn;
            sw  = (s % 16) != 15;
            nx  = (s % 4) == 3;
            up  = 1'($urandom_range(0, 1));
            dn  = 1'($urandom_range(0, 2) == 0);
            dur = $urandom_range(1, 80);
            for (int k = 0; k < dur; k++) begin
                drive(sw, nx, up, dn);
                et = '0;
                if (mf == 0) begin
                    if (sw && !ps) mf = 1;
                    armed = 0;
                end else if (!sw) begin
                    mf = 0;
                    armed = 0;
                end else if (nx && !pn) begin
                    mf = mf % 3 + 1;
                    armed = 0;
                end else if ((up && !pu && !dn) || (dn && !pd && !up)) begin
                    mdir = dn;
                    press = c;
                    armed = 1;
                    et[mf - 1 + (mdir ? 3 : 0)] = 1'b1;
                end else if (armed && (mdir ? (dn && !up) : (up && !dn))) begin
                    if (c - press >= 50 && (c - press - 50) % 20 == 0) et[mf - 1 + (mdir ? 3 : 0)] = 1'b1;
                end else begin
                    armed = 0;
                end
                {ps, pn, pu, pd} = {sw, nx, up, dn};
                c++;
                cyc();
                chk("rand_ticks", tk, et);
                chk("rand_field", field, mf);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
